ins_pair_queue: RTL

- Dual-slot instruction fetch queue in front of the pair-issue checker.
- Fetches sequential 32-bit instructions from instruction memory, buffers them in order, and presents the two oldest as Ins1/Ins2 with their PC.
- Retires 1 or 2 entries per cycle, as the issue stage reports through Pop1/Pop2.
- Supports a redirect flush from branch/jump resolution.

---
 rtl/ins_pair_queue_pkg.sv | 19 +
 rtl/ins_queue_mem.sv | 30 +++
 rtl/ins_pair_queue.sv | 129 ++++++++++++
 3 files changed

// File: rtl/ins_pair_queue_pkg.sv
// rtl/ins_pair_queue_pkg.sv - instruction word type and opcode constants shared by fetch, issue and decode
package ins_pair_queue_pkg;

    typedef logic [31:0] ins_word_t;

    // addi x0,x0,0: harmless filler for empty issue slots
    localparam ins_word_t  INS_NOP    = 32'h0000_0013;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    function automatic logic [6:0] ins_opcode(input ins_word_t ins);
        return ins[6:0];
    endfunction

    function automatic logic ins_is_alu(input ins_word_t ins);
        return (ins[6:0] == OPC_OP) || (ins[6:0] == OPC_OP_IMM);
    endfunction

endpackage

// File: rtl/ins_queue_mem.sv
// rtl/ins_queue_mem.sv - DEPTH x 32 instruction register file, one write port, two async read ports
module ins_queue_mem
    import ins_pair_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  ins_word_t     wr_data,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    output ins_word_t     rd_data0,
    output ins_word_t     rd_data1
);

    // No reset: unoccupied slots are masked to NOP by the queue control.
    ins_word_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data0 = mem_q[rd_addr0];
    assign rd_data1 = mem_q[rd_addr1];

endmodule

// File: rtl/ins_pair_queue.sv
// rtl/ins_pair_queue.sv - dual-slot in-order instruction fetch queue feeding the pair-issue checker
module ins_pair_queue
    import ins_pair_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] Ins1,
    output logic [31:0] Ins2,
    output logic [31:0] PC1,
    output logic        Valid1,
    output logic        Valid2,
    input  logic        Pop1,
    input  logic        Pop2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUT) + 1;

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_nxt;
    logic [OW-1:0] out_q, out_d;
    logic [OW-1:0] drop_q, drop_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q, head_pc_d;

    logic          push;
    logic [1:0]    pop_req;
    logic [CW-1:0] pop_eff;
    logic [31:0]   claimed;
    ins_word_t     rd_data0, rd_data1;

    // Slots already spoken for: stored entries plus live in-flight fetches.
    // Stale fetches (drop) will be discarded, so they hold no slot.
    assign claimed  = 32'(count_q) + 32'(out_q) - 32'(drop_q);
    assign imem_req = reset_n && !flush
                      && (32'(out_q) < 32'(MAX_OUT))
                      && (claimed < 32'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign push    = imem_valid && (drop_q == '0) && !flush;
    assign pop_req = Pop2 ? 2'd2 : (Pop1 ? 2'd1 : 2'd0);
    assign pop_eff = (CW'(pop_req) > count_q) ? count_q : CW'(pop_req);

    always_comb begin
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        out_d      = out_q + OW'(imem_req) - OW'(imem_valid);
        drop_d     = drop_q;
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;

        if (flush) begin
            count_d    = '0;
            rd_ptr_d   = wr_ptr_q;
            drop_d     = out_d;
            fetch_pc_d = flush_pc;
            head_pc_d  = flush_pc;
        end else begin
            if (imem_valid && (drop_q != '0)) begin
                drop_d = drop_q - OW'(1);
            end
            if (imem_req) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            rd_ptr_d  = rd_ptr_q + AW'(pop_eff);
            head_pc_d = head_pc_q + (32'(pop_eff) << 2);
            count_d   = count_q + CW'(push) - pop_eff;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            out_q      <= '0;
            drop_q     <= '0;
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
        end
    end

    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    ins_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk      (clk),
        .wr_en    (push),
        .wr_addr  (wr_ptr_q),
        .wr_data  (imem_rdata),
        .rd_addr0 (rd_ptr_q),
        .rd_addr1 (rd_ptr_nxt),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1)
    );

    assign Valid1 = (count_q != '0);
    assign Valid2 = (count_q > CW'(1));
    assign Ins1   = Valid1 ? rd_data0 : INS_NOP;
    assign Ins2   = Valid2 ? rd_data1 : INS_NOP;
    assign PC1    = head_pc_q;

endmodule
